// File: rtl/arc4_sched.sv
// ARC4 top-level sequencer: launches init, KSA and PRGA engines in turn and
// grants the single-port S memory to whichever engine owns the current phase.
module arc4_sched #(
    parameter int KEY_W    = 24,
    parameter bit RUN_PRGA = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             rdy,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] key,
    output logic [1:0]       phase,
    output logic             init_en,
    output logic             ksa_en,
    output logic             prga_en,
    input  logic             init_rdy,
    input  logic             ksa_rdy,
    input  logic             prga_rdy,
    input  logic [7:0]       init_addr,
    input  logic [7:0]       ksa_addr,
    input  logic [7:0]       prga_addr,
    input  logic [7:0]       init_wrdata,
    input  logic [7:0]       ksa_wrdata,
    input  logic [7:0]       prga_wrdata,
    input  logic             init_wren,
    input  logic             ksa_wren,
    input  logic             prga_wren,
    output logic [7:0]       s_addr,
    output logic [7:0]       s_wrdata,
    output logic             s_wren
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INIT_GO   = 3'd1;
    localparam logic [2:0] ST_INIT_WAIT = 3'd2;
    localparam logic [2:0] ST_KSA_GO    = 3'd3;
    localparam logic [2:0] ST_KSA_WAIT  = 3'd4;
    localparam logic [2:0] ST_PRGA_GO   = 3'd5;
    localparam logic [2:0] ST_PRGA_WAIT = 3'd6;

    logic [2:0]       state_q, state_d;
    logic             rdy_q, rdy_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             seen_low_q, seen_low_d;
    logic             cur_rdy_s;
    logic [2:0]       done_next_s;

    // Ready of the engine owning the current phase, and where its completion leads.
    always_comb begin
        cur_rdy_s   = 1'b0;
        done_next_s = ST_IDLE;
        case (state_q)
            ST_INIT_GO, ST_INIT_WAIT: begin
                cur_rdy_s   = init_rdy;
                done_next_s = ST_KSA_GO;
            end
            ST_KSA_GO, ST_KSA_WAIT: begin
                cur_rdy_s   = ksa_rdy;
                done_next_s = RUN_PRGA ? ST_PRGA_GO : ST_IDLE;
            end
            ST_PRGA_GO, ST_PRGA_WAIT: begin
                cur_rdy_s   = prga_rdy;
                done_next_s = ST_IDLE;
            end
            default: begin
                cur_rdy_s   = 1'b0;
                done_next_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer next-state and control-register update.
    always_comb begin
        state_d    = state_q;
        rdy_d      = rdy_q;
        key_d      = key_q;
        seen_low_d = seen_low_q;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    key_d   = key_in;
                    rdy_d   = 1'b0;
                    state_d = ST_INIT_GO;
                end else begin
                    rdy_d = 1'b1;
                end
            end
            ST_INIT_GO, ST_KSA_GO, ST_PRGA_GO: begin
                // The start pulse fires on this edge; the wait state follows it.
                if (cur_rdy_s) begin
                    state_d    = state_q | 3'b000;
                    state_d    = (state_q == ST_INIT_GO) ? ST_INIT_WAIT :
                                 (state_q == ST_KSA_GO)  ? ST_KSA_WAIT  : ST_PRGA_WAIT;
                    seen_low_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_INIT_WAIT, ST_KSA_WAIT, ST_PRGA_WAIT: begin
                // Completion needs a low-then-high ready, so a stuck-high engine never finishes.
                if (!cur_rdy_s) begin
                    seen_low_d = 1'b1;
                end else if (seen_low_q) begin
                    state_d = done_next_s;
                    rdy_d   = (done_next_s == ST_IDLE);
                end else begin
                    seen_low_d = seen_low_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rdy_d   = 1'b1;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rdy_q      <= 1'b1;
            key_q      <= {KEY_W{1'b0}};
            seen_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdy_q      <= rdy_d;
            key_q      <= key_d;
            seen_low_q <= seen_low_d;
        end
    end

    assign rdy     = rdy_q;
    assign key     = key_q;
    assign init_en = (state_q == ST_INIT_GO) & init_rdy;
    assign ksa_en  = (state_q == ST_KSA_GO)  & ksa_rdy;
    assign prga_en = (state_q == ST_PRGA_GO) & prga_rdy;

    // S-memory grant and phase decode; only the owning engine reaches memory.
    always_comb begin
        s_addr   = 8'd0;
        s_wrdata = 8'd0;
        s_wren   = 1'b0;
        phase    = 2'd0;
        case (state_q)
            ST_INIT_GO, ST_INIT_WAIT: begin
                s_addr   = init_addr;
                s_wrdata = init_wrdata;
                s_wren   = init_wren;
                phase    = 2'd1;
            end
            ST_KSA_GO, ST_KSA_WAIT: begin
                s_addr   = ksa_addr;
                s_wrdata = ksa_wrdata;
                s_wren   = ksa_wren;
                phase    = 2'd2;
            end
            ST_PRGA_GO, ST_PRGA_WAIT: begin
                s_addr   = prga_addr;
                s_wrdata = prga_wrdata;
                s_wren   = prga_wren;
                phase    = 2'd3;
            end
            default: begin
                s_addr   = 8'd0;
                s_wrdata = 8'd0;
                s_wren   = 1'b0;
                phase    = 2'd0;
            end
        endcase
    end

endmodule
